// File: rtl/tlc_interval_timer.sv
// tlc_interval_timer
// Interval timer that sits beside the traffic light controller FSM.
// The FSM asks for an interval with a one-cycle Start pulse and a 2-bit code.
// This block answers with a one-cycle Expired pulse once that many whole
// seconds have elapsed. Seconds come from an internal prescaler that counts
// TICKS_PER_SEC clock cycles per second. Cancel aborts a running interval
// without producing Expired.

module tlc_interval_timer #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int SEC_W         = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [1:0]       IntervalSel,
    input  logic             Cancel,
    output logic             Busy,
    output logic             Expired,
    output logic [SEC_W-1:0] SecondsLeft,
    output logic             SecTick
);

    localparam int                  PRESC_W   = $clog2(TICKS_PER_SEC);
    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [PRESC_W-1:0]  PRESC_ONE = PRESC_W'(1);
    localparam logic [SEC_W-1:0]    SEC_ONE   = SEC_W'(1);
    localparam logic [SEC_W-1:0]    SEC_ZERO  = '0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [SEC_W-1:0]   secs_q, secs_d;
    logic               expired_q, expired_d;
    logic               sec_tick_q, sec_tick_d;

    logic [SEC_W-1:0]   load_secs;
    logic               sec_wrap;
    logic               last_sec;

    // Translate the interval code into the number of whole seconds to load.
    always_comb begin
        load_secs = SEC_W'(1);
        case (IntervalSel)
            2'b00:   load_secs = SEC_W'(1);
            2'b01:   load_secs = SEC_W'(3);
            2'b10:   load_secs = SEC_W'(15);
            default: load_secs = SEC_W'(30);
        endcase
    end

    // A second boundary is reached when the prescaler is at its last count while running;
    // the final one is the boundary that takes the count from 1 to 0.
    always_comb begin
        sec_wrap = (state_q == RUN) && (presc_q == PRESC_MAX);
        last_sec = sec_wrap && (secs_q == SEC_ONE);
    end

    // Next-state logic: Start reloads from any state, then Cancel, then the second countdown.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        secs_d     = secs_q;
        expired_d  = 1'b0;
        sec_tick_d = 1'b0;

        if (Start) begin
            // A restart simply discards whatever time was left, so no Expired comes out
            // even if this edge would have been the final decrement.
            state_d = RUN;
            presc_d = '0;
            secs_d  = load_secs;
        end else if (state_q == RUN) begin
            if (Cancel) begin
                state_d = IDLE;
                presc_d = '0;
                secs_d  = SEC_ZERO;
            end else if (sec_wrap) begin
                presc_d    = '0;
                sec_tick_d = 1'b1;
                if (secs_q != SEC_ZERO) begin
                    secs_d = secs_q - SEC_ONE;
                end
                if (last_sec) begin
                    state_d   = IDLE;
                    expired_d = 1'b1;
                end
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
        end
    end

    // State, prescaler, seconds and pulse registers; reset clears everything at once.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            secs_q     <= '0;
            expired_q  <= 1'b0;
            sec_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            secs_q     <= secs_d;
            expired_q  <= expired_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign Busy        = (state_q == RUN);
    assign Expired     = expired_q;
    assign SecondsLeft = secs_q;
    assign SecTick     = sec_tick_q;

endmodule

// File: tb/tb_tlc_interval_timer.sv
// tb_tlc_interval_timer
// Self-checking bench for tlc_interval_timer with TICKS_PER_SEC=4.
// The reference model remembers only when the current interval was started
// and how long it is; every expected output is derived from elapsed cycles.

module tb_tlc_interval_timer;

    localparam int TPS   = 4;
    localparam int SEC_W = 5;
    localparam int OW    = SEC_W + 3;

    logic             Clk;
    logic             Rst;
    logic             Start;
    logic [1:0]       IntervalSel;
    logic             Cancel;
    logic             Busy;
    logic             Expired;
    logic [SEC_W-1:0] SecondsLeft;
    logic             SecTick;

    int checks = 0;
    int errors = 0;

    // reference model state
    int cyc      = 0;
    bit m_active = 0;
    int m_start  = 0;
    int m_n      = 0;

    tlc_interval_timer #(
        .TICKS_PER_SEC(TPS),
        .SEC_W        (SEC_W)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Start      (Start),
        .IntervalSel(IntervalSel),
        .Cancel     (Cancel),
        .Busy       (Busy),
        .Expired    (Expired),
        .SecondsLeft(SecondsLeft),
        .SecTick    (SecTick)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int sel_secs(input logic [1:0] sel);
        case (sel)
            2'b00:   return 1;
            2'b01:   return 3;
            2'b10:   return 15;
            default: return 30;
        endcase
    endfunction

    // expected {Busy, Expired, SecondsLeft, SecTick} after the most recent edge
    function automatic logic [OW-1:0] model_out();
        int e;
        int total;
        logic b;
        logic x;
        logic t;
        logic [SEC_W-1:0] s;
        if (!m_active) return '0;
        e     = cyc - m_start;
        total = m_n * TPS;
        if (e > total) return '0;
        b = (e < total);
        x = (e == total);
        s = SEC_W'(m_n - e / TPS);
        t = (e > 0) && (e % TPS == 0);
        return {b, x, s, t};
    endfunction

    function automatic logic [OW-1:0] dut_out();
        return {Busy, Expired, SecondsLeft, SecTick};
    endfunction

    // advance one clock edge, update the model from the inputs seen at that edge,
    // and return 1 time unit after the edge
    task automatic step();
        bit in_reset;
        bit do_start;
        bit do_cancel;
        bit busy_before;
        int n_sel;
        in_reset    = Rst;
        do_start    = Start;
        do_cancel   = Cancel;
        n_sel       = sel_secs(IntervalSel);
        busy_before = m_active && ((cyc - m_start) < m_n * TPS);
        @(posedge Clk);
        cyc++;
        if (!in_reset) begin
            if (do_start) begin
                m_active = 1;
                m_start  = cyc;
                m_n      = n_sel;
            end else if (do_cancel && busy_before) begin
                m_active = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [OW-1:0] exp_v;
        Rst         = 1'b1;
        Start       = 1'b1;
        IntervalSel = 2'b11;
        Cancel      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (dut_out() !== '0) begin
                errors++;
                $display("[TB] FAIL reset_hold cyc=%0d got=%b want=0", cyc, dut_out());
            end
        end
        Rst   = 1'b0;
        Start = 1'b0;
        step();
        checks++;
        if (dut_out() !== '0) begin
            errors++;
            $display("[TB] FAIL reset_release got=%b want=0", dut_out());
        end
        Start       = 1'b1;
        IntervalSel = 2'b01;
        step();
        Start = 1'b0;
        step();
        step();
        exp_v = model_out();
        checks++;
        if (dut_out() !== exp_v) begin
            errors++;
            $display("[TB] FAIL reset_prerun got=%b want=%b", dut_out(), exp_v);
        end
        #2;
        Rst      = 1'b1;
        m_active = 0;
        #1;
        checks++;
        if (dut_out() !== '0) begin
            errors++;
            $display("[TB] FAIL reset_async got=%b want=0", dut_out());
        end
        step();
        Rst = 1'b0;
        step();
        checks++;
        if (dut_out() !== '0) begin
            errors++;
            $display("[TB] FAIL reset_after_async got=%b want=0", dut_out());
        end
    endtask

    task automatic test_basic();
        logic [OW-1:0] exp_v;
        int exp_at;
        int n_exp;
        exp_at      = -1;
        n_exp       = 0;
        Start       = 1'b1;
        IntervalSel = 2'b01;
        step();
        Start = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            checks++;
            exp_v = model_out();
            if (dut_out() !== exp_v) begin
                errors++;
                $display("[TB] FAIL basic off=%0d got=%b want=%b", i - 1, dut_out(), exp_v);
            end
            if (Expired === 1'b1) begin
                n_exp++;
                exp_at = i - 1;
            end
            step();
        end
        checks++;
        if (n_exp != 1 || exp_at != 12) begin
            errors++;
            $display("[TB] FAIL basic_expired_edge got=%0d pulses at %0d want=1 at 12", n_exp, exp_at);
        end
    endtask

    task automatic test_all_intervals();
        logic [OW-1:0] exp_v;
        for (int s = 0; s < 4; s++) begin
            Start       = 1'b1;
            IntervalSel = 2'(s);
            step();
            Start = 1'b0;
            for (int i = 0; i < sel_secs(2'(s)) * TPS + 3; i++) begin
                checks++;
                exp_v = model_out();
                if (dut_out() !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL interval sel=%0d off=%0d got=%b want=%b", s, i, dut_out(), exp_v);
                end
                step();
            end
        end
    endtask

    task automatic test_cancel();
        logic [OW-1:0] exp_v;
        Start       = 1'b1;
        IntervalSel = 2'b11;
        step();
        Start = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            Cancel = (i == 50);
            step();
            checks++;
            exp_v = model_out();
            if (dut_out() !== exp_v) begin
                errors++;
                $display("[TB] FAIL cancel off=%0d got=%b want=%b", i, dut_out(), exp_v);
            end
        end
        Cancel = 1'b0;
        checks++;
        if (Busy !== 1'b0 || SecondsLeft !== '0) begin
            errors++;
            $display("[TB] FAIL cancel_idle got busy=%b secs=%0d want busy=0 secs=0", Busy, SecondsLeft);
        end
        Cancel = 1'b1;
        step();
        Cancel = 1'b0;
        checks++;
        if (dut_out() !== '0) begin
            errors++;
            $display("[TB] FAIL cancel_in_idle got=%b want=0", dut_out());
        end
    endtask

    task automatic test_restart();
        logic [OW-1:0] exp_v;
        Start       = 1'b1;
        IntervalSel = 2'b10;
        step();
        for (int i = 1; i <= 20; i++) begin
            Start       = (i == 10);
            IntervalSel = 2'b00;
            step();
            checks++;
            exp_v = model_out();
            if (dut_out() !== exp_v) begin
                errors++;
                $display("[TB] FAIL restart off=%0d got=%b want=%b", i, dut_out(), exp_v);
            end
        end
        Start = 1'b0;
    endtask

    task automatic test_start_on_final();
        logic [OW-1:0] exp_v;
        Start       = 1'b1;
        IntervalSel = 2'b00;
        step();
        for (int i = 1; i <= 11; i++) begin
            Start = (i == 4);
            step();
            checks++;
            exp_v = model_out();
            if (dut_out() !== exp_v) begin
                errors++;
                $display("[TB] FAIL final_restart off=%0d got=%b want=%b", i, dut_out(), exp_v);
            end
        end
        Start = 1'b0;
    endtask

    task automatic test_reset_mid_interval();
        logic [OW-1:0] exp_v;
        Start       = 1'b1;
        IntervalSel = 2'b01;
        step();
        Start = 1'b0;
        for (int i = 1; i <= 6; i++) step();
        Rst      = 1'b1;
        m_active = 0;
        #1;
        checks++;
        if (dut_out() !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_immediate got=%b want=0", dut_out());
        end
        step();
        step();
        Rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (dut_out() !== '0) begin
                errors++;
                $display("[TB] FAIL midreset_quiet off=%0d got=%b want=0", i, dut_out());
            end
        end
        Start       = 1'b1;
        IntervalSel = 2'b01;
        step();
        Start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            checks++;
            exp_v = model_out();
            if (dut_out() !== exp_v) begin
                errors++;
                $display("[TB] FAIL midreset_restart off=%0d got=%b want=%b", i, dut_out(), exp_v);
            end
            step();
        end
    endtask

    task automatic test_held_start();
        logic [OW-1:0] exp_v;
        Start       = 1'b1;
        IntervalSel = 2'b00;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            exp_v = model_out();
            if (dut_out() !== exp_v || Expired !== 1'b0) begin
                errors++;
                $display("[TB] FAIL held_start off=%0d got=%b want=%b", i, dut_out(), exp_v);
            end
        end
        Start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            exp_v = model_out();
            if (dut_out() !== exp_v) begin
                errors++;
                $display("[TB] FAIL held_release off=%0d got=%b want=%b", i, dut_out(), exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [OW-1:0] exp_v;
        int r;
        for (int i = 0; i < 1500; i++) begin
            r           = $urandom_range(0, 99);
            Start       = (r < 4) || (r >= 8 && r < 10);
            Cancel      = (r >= 4 && r < 10);
            IntervalSel = 2'($urandom_range(0, 3));
            step();
            checks++;
            exp_v = model_out();
            if (dut_out() !== exp_v || (Busy === 1'b1 && Expired === 1'b1)) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d got=%b want=%b", cyc, dut_out(), exp_v);
            end
        end
        Start  = 1'b0;
        Cancel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_intervals();
        test_cancel();
        test_restart();
        test_start_on_final();
        test_reset_mid_interval();
        test_held_start();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
